pipelined_datapath: RTL

- Parametrised, three-stage pipelined successor to the single-cycle datapath: register read (S1), execute/memory (S2), writeback (S3).
- Accepts one micro-op per cycle from the control unit over a valid/ready handshake.
- Forwards results between stages; inserts a one-cycle stall on load-use hazards.
- Contains a 2-read/1-write register file, a synchronous-read data RAM, an ALU with a load-immediate op, and a registered zero flag.

---
 rtl/datapath_pkg.sv | 60 ++++++
 rtl/reg_file_2r1w.sv | 30 +++
 rtl/pipelined_datapath.sv | 124 ++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared types, default widths and the ALU for the pipelined datapath.
package datapath_pkg;

  localparam int DP_DATA_W = 16;
  localparam int DP_RF_AW  = 4;
  localparam int DP_MEM_AW = 8;
  localparam int ALU_MAX_W = 64;

  typedef enum logic [2:0] {
    ALU_PASSA = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_NOTA  = 3'd6,
    ALU_IMM   = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    rf_w_en;
    logic    rf_s;
    logic    d_wr;
    alu_op_e alu_s;
  } ctrl_t;

  typedef struct packed {
    logic                 rf_w_en;
    logic                 rf_s;
    logic                 d_wr;
    alu_op_e              alu_s;
    logic [DP_RF_AW-1:0]  w_addr;
    logic [DP_RF_AW-1:0]  ra_addr;
    logic [DP_RF_AW-1:0]  rb_addr;
    logic [DP_MEM_AW-1:0] d_addr;
    logic [DP_DATA_W-1:0] imm;
  } uop_t;

  // Evaluated at a wide width; callers truncate, which gives modulo-2**W results.
  function automatic logic [ALU_MAX_W-1:0] alu_eval(input alu_op_e op,
                                                    input logic [ALU_MAX_W-1:0] a,
                                                    input logic [ALU_MAX_W-1:0] b,
                                                    input logic [ALU_MAX_W-1:0] imm);
    logic [ALU_MAX_W-1:0] r;
    r = a;
    case (op)
      ALU_PASSA: r = a;
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_NOTA:  r = ~a;
      ALU_IMM:   r = imm;
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Two combinational read ports, one write port, synchronous clear.
module reg_file_2r1w #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              we,
  input  logic [RF_AW-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RF_AW-1:0]  raddr_a,
  input  logic [RF_AW-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [2**RF_AW];

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      for (int i = 0; i < 2**RF_AW; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/pipelined_datapath.sv
// Three-stage datapath: S1 operand read/forward, S2 execute and RAM access, S3 writeback.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int RF_AW  = DP_RF_AW,
  parameter int MEM_AW = DP_MEM_AW
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Op_valid,
  output logic              Op_ready,
  input  logic [MEM_AW-1:0] D_Addr,
  input  logic              D_wr,
  input  logic              RF_W_en,
  input  logic              RF_s,
  input  logic [RF_AW-1:0]  RF_W_addr,
  input  logic [RF_AW-1:0]  RF_Ra_addr,
  input  logic [RF_AW-1:0]  RF_Rb_addr,
  input  logic [2:0]        Alu_s,
  input  logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              Wb_valid,
  output logic [RF_AW-1:0]  Wb_addr,
  output logic [DATA_W-1:0] Wb_data,
  output logic              Zero
);

  logic              s2_valid;
  ctrl_t             s2_ctrl;
  logic [RF_AW-1:0]  s2_waddr;
  logic [MEM_AW-1:0] s2_daddr;
  logic [DATA_W-1:0] s2_imm;

  logic              s3_valid;
  logic              s3_we;
  logic              s3_rf_s;
  logic [RF_AW-1:0]  s3_waddr;
  logic [DATA_W-1:0] s3_alu;

  logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b, ram_q;
  logic              hazard, accept, s2_fwd_ok;

  logic [DATA_W-1:0] ram [2**MEM_AW];

  reg_file_2r1w #(.DATA_W(DATA_W), .RF_AW(RF_AW)) u_rf (
    .clk_sys (Clk),
    .rst_b   (Reset_n),
    .we      (Wb_valid),
    .waddr   (Wb_addr),
    .wdata   (Wb_data),
    .raddr_a (RF_Ra_addr),
    .raddr_b (RF_Rb_addr),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  assign ALU_Out = DATA_W'(alu_eval(s2_ctrl.alu_s, ALU_MAX_W'(A), ALU_MAX_W'(B),
                                    ALU_MAX_W'(s2_imm)));

  assign Wb_valid = s3_valid && s3_we;
  assign Wb_addr  = s3_waddr;
  assign Wb_data  = s3_rf_s ? ram_q : s3_alu;

  // Both sources are compared even when the op does not use them.
  assign hazard   = s2_valid && s2_ctrl.rf_w_en && s2_ctrl.rf_s &&
                    ((RF_Ra_addr == s2_waddr) || (RF_Rb_addr == s2_waddr));
  assign Op_ready = !hazard;
  assign accept   = Op_valid && Op_ready;

  assign s2_fwd_ok = s2_valid && s2_ctrl.rf_w_en && !s2_ctrl.rf_s;

  always_comb begin
    fwd_a = rf_a;
    if (s2_fwd_ok && (RF_Ra_addr == s2_waddr)) fwd_a = ALU_Out;
    else if (Wb_valid && (RF_Ra_addr == Wb_addr)) fwd_a = Wb_data;
    fwd_b = rf_b;
    if (s2_fwd_ok && (RF_Rb_addr == s2_waddr)) fwd_b = ALU_Out;
    else if (Wb_valid && (RF_Rb_addr == Wb_addr)) fwd_b = Wb_data;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_ctrl  <= '0;
      s2_waddr <= '0;
      s2_daddr <= '0;
      s2_imm   <= '0;
      A        <= '0;
      B        <= '0;
      s3_valid <= 1'b0;
      s3_we    <= 1'b0;
      s3_rf_s  <= 1'b0;
      s3_waddr <= '0;
      s3_alu   <= '0;
      Zero     <= 1'b0;
    end else begin
      s2_valid <= accept;
      if (accept) begin
        s2_ctrl  <= '{rf_w_en: RF_W_en, rf_s: RF_s, d_wr: D_wr, alu_s: alu_op_e'(Alu_s)};
        s2_waddr <= RF_W_addr;
        s2_daddr <= D_Addr;
        s2_imm   <= Imm;
        A        <= fwd_a;
        B        <= fwd_b;
      end
      s3_valid <= s2_valid;
      s3_we    <= s2_ctrl.rf_w_en;
      s3_rf_s  <= s2_ctrl.rf_s;
      s3_waddr <= s2_waddr;
      s3_alu   <= ALU_Out;
      if (s2_valid && !(s2_ctrl.rf_w_en && s2_ctrl.rf_s)) Zero <= (ALU_Out == '0);
    end
  end

  // RAM contents survive reset; only the write is gated by it.
  always_ff @(posedge Clk) begin
    if (Reset_n && s2_valid && s2_ctrl.d_wr) ram[s2_daddr] <= A;
    ram_q <= ram[s2_daddr];
  end

endmodule
